// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract unit: one carry slice resolved per stage,
// valid/ready on both sides. Define ADDSUB_SATURATE_EN to clamp signed overflow.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0]            vQ, cQ, adv, srcV, srcC, nxtC;
  logic [STAGES-1:0][WIDTH-1:0] aQ, bQ, rQ, srcA, srcB, srcR, nxtR;
  logic                         ovQ, zQ, ovNext, zNext;
  logic                         unusedLastOperands;

  // Adds slice k of a and b with carry-in c, merging the slice into the partial result r.
  function automatic logic [WIDTH:0] resolveSlice(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] r,
                                                  input logic             c,
                                                  input int               k);
    logic [SW:0]      s;
    logic [WIDTH-1:0] res;
    s = {1'b0, a[k*SW +: SW]} + {1'b0, b[k*SW +: SW]} + {{SW{1'b0}}, c};
    res = r;
    res[k*SW +: SW] = s[SW-1:0];
    return {s[SW], res};
  endfunction

  // Back-pressure ripples from the consumer down to the input, with no skid buffer.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vQ[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !vQ[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0];

  always_comb begin
    srcV   = '0;
    srcC   = '0;
    srcA   = '0;
    srcB   = '0;
    srcR   = '0;
    nxtC   = '0;
    nxtR   = '0;
    ovNext = 1'b0;
    zNext  = 1'b0;
    srcV[0] = in_valid;
    srcA[0] = in1;
    srcB[0] = sub ? ~in2 : in2;
    srcC[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      srcV[k] = vQ[k-1];
      srcA[k] = aQ[k-1];
      srcB[k] = bQ[k-1];
      srcR[k] = rQ[k-1];
      srcC[k] = cQ[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      {nxtC[k], nxtR[k]} = resolveSlice(srcA[k], srcB[k], srcR[k], srcC[k], k);
    end
    ovNext = (srcA[STAGES-1][WIDTH-1] == srcB[STAGES-1][WIDTH-1]) &&
             (nxtR[STAGES-1][WIDTH-1] != srcA[STAGES-1][WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    if (ovNext) begin
      nxtR[STAGES-1] = srcA[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zNext = (nxtR[STAGES-1] == '0);
  end

  // Data registers only load when a real operation arrives, so a stalled output holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vQ  <= '0;
      cQ  <= '0;
      aQ  <= '0;
      bQ  <= '0;
      rQ  <= '0;
      ovQ <= 1'b0;
      zQ  <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vQ[k] <= srcV[k];
          if (srcV[k]) begin
            aQ[k] <= srcA[k];
            bQ[k] <= srcB[k];
            rQ[k] <= nxtR[k];
            cQ[k] <= nxtC[k];
          end
        end
      end
      if (adv[STAGES-1] && srcV[STAGES-1]) begin
        ovQ <= ovNext;
        zQ  <= zNext;
      end
    end
  end

  assign unusedLastOperands = &{1'b0, aQ[STAGES-1], bQ[STAGES-1]};

  assign out_valid = vQ[STAGES-1];
  assign out       = rQ[STAGES-1];
  assign carry     = cQ[STAGES-1];
  assign overflow  = ovQ;
  assign zero      = zQ;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub (WIDTH=16, STAGES=2): an arithmetic model pushes
// expected results on accept, and they are popped and compared as the unit drains.
module tb_pipelined_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        carry;
  logic        overflow;
  logic        zero;

  int          checks = 0;
  int          failures = 0;
  int          resultsSeen = 0;
  logic [18:0] expQ[$];
  logic        holdArmed = 1'b0;
  logic [18:0] heldSnap = '0;

  pipelined_addsub #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry(carry), .overflow(overflow), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {out, carry, overflow, zero}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] bp;
    logic [16:0] full;
    logic [15:0] r;
    logic        ov;
    bp   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {16'h0, s};
    r    = full[15:0];
    ov   = (a[15] == bp[15]) && (r[15] != a[15]);
`ifdef ADDSUB_SATURATE_EN
    if (ov) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {r, full[16], ov, (r == 16'h0000)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s);
    int waitCycles;
    waitCycles = 0;
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    sub = s;
    @(negedge clk);
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string tag);
    for (int c = 0; c < 100 && expQ.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: records accepted operations, scores drained results, and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      holdArmed = 1'b0;
    end else begin
      if (holdArmed) begin
        checkOutput("stallValid", 32'(out_valid), 32'd1);
        checkOutput("stallHold", 32'({out, carry, overflow, zero}), 32'(heldSnap));
      end
      holdArmed = out_valid && !out_ready;
      heldSnap  = {out, carry, overflow, zero};
      if (in_valid && in_ready) expQ.push_back(model(in1, in2, sub));
      if (out_valid && out_ready) begin
        resultsSeen++;
        if (expQ.size() == 0) checkOutput("unexpectedResult", 32'(out), 32'hDEAD_0000);
        else checkOutput("result", 32'({out, carry, overflow, zero}), 32'(expQ.pop_front()));
      end
    end
  end

  initial begin
    int target;
    int staleCount;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOut", 32'(out), 32'd0);
    checkOutput("rstFlags", 32'({carry, overflow, zero}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    applyStimulus(16'h0000, 16'h0001, 1'b0);
    in_valid = 1'b0;
    checkOutput("latencyEdge1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("latencyEdge2", 32'(out_valid), 32'd1);
    checkOutput("firstSum", 32'({out, carry, overflow, zero}), 32'({16'h0001, 1'b0, 1'b0, 1'b0}));
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b1);
    applyStimulus(16'h1234, 16'h1234, 1'b1);
    applyStimulus(16'hA5A5, 16'h5A5B, 1'b0);
    in_valid = 1'b0;
    waitDrain("directedDrain");

    $display("[TB] stream with mid-stream stall");
    target = resultsSeen + 10;
    fork
      begin
        for (int i = 0; i <= 14; i += 2)
          for (int j = 0; j <= 15; j += 5)
            applyStimulus(16'(i), 16'(j), 1'b0);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 200 && resultsSeen < target; c++) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("stallInReady", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain("streamDrain");
    checkOutput("streamCount", 32'(resultsSeen - target + 10), 32'd32);

    $display("[TB] reset with operations in flight");
    out_ready = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    applyStimulus(16'h3333, 16'h4444, 1'b1);
    in_valid = 1'b0;
    checkOutput("fullInReady", 32'(in_ready), 32'd0);
    checkOutput("fullOutValid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(out_valid), 32'd0);
    expQ.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    checkOutput("postRstInReady", 32'(in_ready), 32'd1);
    staleCount = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) staleCount++;
    end
    checkOutput("noStaleResult", 32'(staleCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement add/subtract unit. It is the sequential successor to the 16-bit combinational adder and sits in the processor ALU datapath. The operand word is split into STAGES equal slices, and one slice is resolved per pipeline stage with the carry registered between stages. A valid/ready handshake on both sides supports back-pressure, and the unit produces carry, overflow and zero flags.

Parameters:
WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
STAGES, 2, number of pipeline stages and carry slices; 1..WIDTH; latency in cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode valid this cycle
in_ready  output  1  unit accepts the operation this cycle
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts the result
out  output  WIDTH  sum/difference
carry  output  1  carry out of MSB; for sub, 1 = no borrow
overflow  output  1  signed overflow
zero  output  1  out == 0

Behaviour:
- Reset: rst_n low clears, asynchronously, all stage valid bits, out_valid, out, carry, overflow and zero to 0. in_ready reads 1 while the pipeline is empty.
- Operand handling: B' = sub ? ~in2 : in2. The carry-in of slice 0 is sub. Slice k covers bits [(k+1)*W/S-1 : k*W/S].
- Stage k resolves slice k using A, B' and the registered carry from stage k-1.
  - Upper unresolved operand slices and sub travel with the operation.
  - Resolved lower result slices accumulate in the stage registers.
- Latency: an operation accepted at edge N presents out_valid=1 with its result after edge N+STAGES-1, i.e. STAGES register stages. With no stalls, throughput is one operation per cycle.
- Handshake:
  - An input transfer occurs when in_valid and in_ready are both 1 at a rising edge.
  - An output transfer occurs when out_valid and out_ready are both 1.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances when it is empty or out_ready=1.
  - in_ready = !stage0_valid || stage0 advances. It is combinational from out_ready through the chain; no skid buffer.
  - While out_valid=1 and out_ready=0, out and the flags are held stable.
  - A full pipeline holds STAGES operations. When stalled, in_ready=0 and no operation is lost or duplicated.
- Simultaneous events: input accept and output drain in the same cycle are legal when full; the pipeline shifts and occupancy is unchanged.
- Flags, computed in the last stage:
  - carry = carry out of the MSB.
  - overflow = (A[MSB]==B'[MSB]) && (out[MSB]!=A[MSB]).
  - zero = (out == 0), using the final out after any saturation.
- Ordering: results are strictly in acceptance order.
- Reset mid-operation discards all in-flight operations. After release, no stale result appears.
- STAGES=1: single registered adder with latency 1.

Optional Feature:
Macro ADDSUB_SATURATE_EN.
- When defined: on overflow=1, out clamps to the signed maximum (0x7FFF for WIDTH=16) if A[MSB]=0, or to the signed minimum (0x8000) if A[MSB]=1. overflow remains 1, carry is unchanged, and zero is recomputed on the clamped value.
- When undefined: out is the wrapped result. There is no clamp logic, and timing and latency are identical in both builds.

Test Plan (WIDTH=16, STAGES=2, out_ready=1 unless noted):
1. 0x0000 + 0x0001 -> out=0x0001 two edges after accept; carry=0, overflow=0, zero=0.
2. 0xFFFF + 0x0001 -> out=0x0000, carry=1, zero=1, overflow=0. Checks the carry crossing the slice boundary at bit 8.
3. 0x7FFF + 0x0001 -> out=0x8000, overflow=1. With ADDSUB_SATURATE_EN: out=0x7FFF, overflow=1, zero=0.
4. sub: 0x0005 - 0x0007 -> out=0xFFFE, carry=0 (borrow), overflow=0. Also 0x8000 - 0x0001 -> 0x7FFF, overflow=1.
5. Stream in1=i (i=0,2,...,14) x in2=j (j=0,5,10,15) back-to-back, with out_ready held 0 for 3 cycles mid-stream -> in_ready drops once 2 operations are held, outputs stay stable while stalled, and all 32 results equal (i+j)&0xFFFF in order.
6. Assert rst_n=0 with 2 operations in flight -> out_valid=0 immediately (asynchronously), no results after release, and in_ready=1.
